// File: rtl/match_event_monitor_if.sv
// Signal bundle between the equality detector side and the match event monitor.
// CNT_W must match the monitor's CNT_W parameter.
interface match_event_monitor_if #(
   parameter int CNT_W = 8
);
   logic             z;
   logic             ack;
   logic             clr;
   logic [CNT_W-1:0] event_cnt;
   logic [3:0]       win_cnt;
   logic             alarm;
   logic [1:0]       state;

   modport master (output z, ack, clr, input event_cnt, win_cnt, alarm, state);
   modport slave  (input z, ack, clr, output event_cnt, win_cnt, alarm, state);
endinterface

// File: rtl/match_event_monitor.sv
// Counts rising edges of the detector's match pulse and latches an alarm when
// THRESH events land within a WIN-cycle window.
//
// state  | meaning
// IDLE   | no window open, waiting for the first event
// WINDOW | window open, tmr counting down the remaining cycles
// ALARM  | THRESH events seen in one window, alarm held until ack
module match_event_monitor #(
   parameter int CNT_W  = 8,
   parameter int WIN    = 16,
   parameter int THRESH = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   match_event_monitor_if.slave  bus
);
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WINDOW = 2'd1,
      ALARM  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [7:0]       TMR_LOAD = 8'(WIN - 1);
   localparam logic [3:0]       THRESH_V = 4'(THRESH);

   state_t           state_q, state_d;
   logic             z_q;
   logic             evt;
   logic [CNT_W-1:0] event_cnt_q, event_cnt_d;
   logic [3:0]       win_q, win_d, win_inc;
   logic [7:0]       tmr_q, tmr_d;
   logic             alarm_q;

   assign evt     = bus.z & ~z_q;
   assign win_inc = win_q + 4'd1;

   always_comb begin
      state_d     = state_q;
      win_d       = win_q;
      tmr_d       = tmr_q;
      event_cnt_d = event_cnt_q;

      if (evt && (event_cnt_q != CNT_MAX))
         event_cnt_d = event_cnt_q + 1'b1;

      if (bus.clr) begin
         state_d     = IDLE;
         win_d       = '0;
         tmr_d       = '0;
         event_cnt_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (evt) begin
                  win_d = 4'd1;
                  if (THRESH == 1) begin
                     state_d = ALARM;
                  end else begin
                     state_d = WINDOW;
                     tmr_d   = TMR_LOAD;
                  end
               end else begin
                  win_d = '0;
               end
            end
            WINDOW: begin
               // A last-cycle event still gets its chance to reach THRESH.
               if (evt && (win_inc == THRESH_V)) begin
                  win_d   = win_inc;
                  state_d = ALARM;
               end else if (tmr_q == 8'd1) begin
                  win_d   = '0;
                  state_d = IDLE;
               end else begin
                  tmr_d = tmr_q - 8'd1;
                  if (evt)
                     win_d = win_inc;
               end
            end
            ALARM: begin
               if (bus.ack) begin
                  win_d   = '0;
                  state_d = IDLE;
               end
            end
            default: begin
               win_d   = '0;
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         z_q         <= 1'b0;
         event_cnt_q <= '0;
         win_q       <= '0;
         tmr_q       <= '0;
         alarm_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         z_q         <= bus.z;
         event_cnt_q <= event_cnt_d;
         win_q       <= win_d;
         tmr_q       <= tmr_d;
         alarm_q     <= (state_d == ALARM);
      end
   end

   assign bus.event_cnt = event_cnt_q;
   assign bus.win_cnt   = win_q;
   assign bus.alarm     = alarm_q;
   assign bus.state     = state_q;
endmodule
